// File: rtl/shifter_pkg.sv
// Shared encodings for the iterative barrel shifter:
// shift modes and FSM states.
package shifter_pkg;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SHIFT  = 2'b01,
    ST_FINISH = 2'b10
  } state_t;

endpackage

// File: rtl/iterative_barrel_shifter_shift_step.sv
// One combinational shift of {carry, data} by 0..STEP
// positions, built as log2 mux levels of power-of-2 shifts.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 8,
  parameter int SW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH:0]  din,
  input  logic [1:0]      mode,
  input  logic [SW-1:0]   s,
  output logic [WIDTH:0]  dout
);

  logic [SW:0][WIDTH:0] lvl;

  assign lvl[0] = din;

  for (genvar j = 0; j < SW; j++) begin : g_lvl
    localparam int AMT = 1 << j;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] rot;
    logic [WIDTH:0]   sh;

    assign d   = lvl[j][WIDTH-1:0];
    assign rot = (d >> AMT) | (d << (WIDTH - AMT));

    // Carry tracks the last bit out; for ROR it is the new MSB.
    always_comb begin
      sh = lvl[j];
      unique case (mode)
        SH_LSL: sh = lvl[j] << AMT;
        SH_LSR: sh = {d[AMT-1], d >> AMT};
        SH_ASR: sh = {d[AMT-1], WIDTH'($signed(d) >>> AMT)};
        SH_ROR: sh = {rot[WIDTH-1], rot};
      endcase
    end

    assign lvl[j+1] = s[j] ? sh : lvl[j];
  end

  assign dout = lvl[SW];

endmodule

// File: rtl/iterative_barrel_shifter.sv
// Multi-cycle LSL/LSR/ASR/ROR unit with ARM shifter carry;
// shifts up to STEP positions per cycle.
module iterative_barrel_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 8,
  parameter int STEP    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   A,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               carry_in,
  output logic               ready,
  output logic               done,
  output logic [WIDTH-1:0]   Y,
  output logic               carry_out
);

  localparam int REM_W = $clog2(WIDTH + 2);
  localparam int SW    = $clog2(STEP + 1);
  localparam int LW    = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH:0]   work_q, work_d;
  logic [1:0]       mode_q, mode_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             co_q, co_d;

  logic [REM_W-1:0] eff;
  logic [REM_W-1:0] rem_nxt;
  logic [SW-1:0]    step_s;
  logic [WIDTH:0]   step_out;

  // Clamps let the WIDTH+1-bit register produce ARM edge results.
  always_comb begin
    eff = '0;
    if (shamt != '0) begin
      unique case (mode)
        SH_LSL, SH_LSR:
          eff = (shamt > SHAMT_W'(WIDTH)) ?
                REM_W'(WIDTH + 1) : REM_W'(shamt);
        SH_ASR:
          eff = (shamt >= SHAMT_W'(WIDTH)) ?
                REM_W'(WIDTH) : REM_W'(shamt);
        SH_ROR:
          eff = (shamt[LW-1:0] == '0) ?
                REM_W'(WIDTH) : REM_W'(shamt[LW-1:0]);
      endcase
    end
  end

  assign step_s  = (rem_q > REM_W'(STEP)) ?
                   SW'(STEP) : SW'(rem_q);
  assign rem_nxt = rem_q - REM_W'(step_s);

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .SW    (SW)
  ) u_step (
    .din   (work_q),
    .mode  (mode_q),
    .s     (step_s),
    .dout  (step_out)
  );

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    y_d     = y_q;
    co_d    = co_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          work_d = {carry_in, A};
          mode_d = mode;
          rem_d  = eff;
          if (eff == '0) begin
            state_d = ST_FINISH;
            y_d     = A;
            co_d    = carry_in;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        work_d = step_out;
        rem_d  = rem_nxt;
        if (rem_nxt == '0) begin
          state_d = ST_FINISH;
          y_d     = step_out[WIDTH-1:0];
          co_d    = step_out[WIDTH];
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      mode_q  <= SH_LSL;
      rem_q   <= '0;
      y_q     <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      y_q     <= y_d;
      co_q    <= co_d;
    end
  end

  assign ready     = (state_q == ST_IDLE);
  assign done      = (state_q == ST_FINISH);
  assign Y         = y_q;
  assign carry_out = co_q;

endmodule

// File: tb/tb_iterative_barrel_shifter.sv
// Directed-vector bench for iterative_barrel_shifter
// (WIDTH=32, STEP=8), plus handshake and reset sequences.
module tb_iterative_barrel_shifter;
  import shifter_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  mode_i;
  logic [31:0] a_i;
  logic [7:0]  shamt_i;
  logic        ci_i;
  logic        ready;
  logic        done;
  logic [31:0] y_o;
  logic        co_o;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  iterative_barrel_shifter #(
    .WIDTH   (32),
    .SHAMT_W (8),
    .STEP    (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode_i),
    .A         (a_i),
    .shamt     (shamt_i),
    .carry_in  (ci_i),
    .ready     (ready),
    .done      (done),
    .Y         (y_o),
    .carry_out (co_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] a;
    logic [7:0]  shamt;
    logic        ci;
    int          lat;
    logic [31:0] y;
    logic        co;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Called #1 after an edge; returns #1 after the done edge.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int d0;

    vecs[0]  = '{SH_ASR, 32'h8000_00F0, 8'd4,   1'b0, 2, 32'hF800_000F, 1'b0};
    vecs[1]  = '{SH_LSR, 32'h8000_0001, 8'd32,  1'b0, 5, 32'h0000_0000, 1'b1};
    vecs[2]  = '{SH_LSR, 32'h8000_0001, 8'd33,  1'b0, 6, 32'h0000_0000, 1'b0};
    vecs[3]  = '{SH_LSL, 32'h0000_0001, 8'd200, 1'b0, 6, 32'h0000_0000, 1'b0};
    vecs[4]  = '{SH_LSL, 32'h0000_0001, 8'd0,   1'b1, 1, 32'h0000_0001, 1'b1};
    vecs[5]  = '{SH_ROR, 32'h8000_0001, 8'd64,  1'b0, 5, 32'h8000_0001, 1'b1};
    vecs[6]  = '{SH_ROR, 32'h8000_0001, 8'd1,   1'b0, 2, 32'hC000_0000, 1'b1};
    vecs[7]  = '{SH_LSL, 32'h0000_0001, 8'd32,  1'b0, 5, 32'h0000_0000, 1'b1};
    vecs[8]  = '{SH_LSL, 32'h1234_5678, 8'd4,   1'b0, 2, 32'h2345_6780, 1'b1};
    vecs[9]  = '{SH_LSR, 32'h1234_5678, 8'd4,   1'b0, 2, 32'h0123_4567, 1'b1};
    vecs[10] = '{SH_ASR, 32'h8000_0000, 8'd40,  1'b0, 5, 32'hFFFF_FFFF, 1'b1};
    vecs[11] = '{SH_ASR, 32'h7FFF_FFFF, 8'd100, 1'b1, 5, 32'h0000_0000, 1'b0};
    vecs[12] = '{SH_ROR, 32'h1234_5678, 8'd12,  1'b0, 3, 32'h6781_2345, 1'b0};
    vecs[13] = '{SH_ROR, 32'h0000_0001, 8'd31,  1'b1, 5, 32'h0000_0002, 1'b0};
    vecs[14] = '{SH_ASR, 32'hF000_0100, 8'd9,   1'b0, 3, 32'hFFF8_0000, 1'b1};
    vecs[15] = '{SH_LSR, 32'h0000_0000, 8'd0,   1'b0, 1, 32'h0000_0000, 1'b0};
    vecs[16] = '{SH_ROR, 32'h8000_0000, 8'd0,   1'b0, 1, 32'h8000_0000, 1'b0};
    vecs[17] = '{SH_LSR, 32'h0000_0010, 8'd4,   1'b1, 2, 32'h0000_0001, 1'b0};

    rst_n   = 1'b0;
    start   = 1'b0;
    mode_i  = SH_LSL;
    a_i     = '0;
    shamt_i = '0;
    ci_i    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_done",  64'(done),  64'd0);
    chk("rst_y",     64'(y_o),   64'd0);
    chk("rst_co",    64'(co_o),  64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 18; i++) begin
      chk($sformatf("v%0d_ready_in", i), 64'(ready), 64'd1);
      mode_i  = vecs[i].mode;
      a_i     = vecs[i].a;
      shamt_i = vecs[i].shamt;
      ci_i    = vecs[i].ci;
      start   = 1'b1;
      @(posedge clk); #1;
      start   = 1'b0;
      wait_done(lat);
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("v%0d_y", i),   64'(y_o), 64'(vecs[i].y));
      chk($sformatf("v%0d_co", i),  64'(co_o), 64'(vecs[i].co));
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_low", i), 64'(done), 64'd0);
      chk($sformatf("v%0d_y_hold", i), 64'(y_o), 64'(vecs[i].y));
    end

    // Start held through SHIFT with new operands, then a
    // back-to-back accept on the cycle ready rises.
    d0      = done_cnt;
    mode_i  = SH_LSR;
    a_i     = 32'hF008_0000;
    shamt_i = 8'd20;
    ci_i    = 1'b0;
    start   = 1'b1;
    @(posedge clk); #1;
    mode_i  = SH_LSL;
    a_i     = 32'hFFFF_FFFF;
    shamt_i = 8'd1;
    chk("hs_busy", 64'(ready), 64'd0);
    wait_done(lat);
    chk("hs1_lat", 64'(lat),  64'd4);
    chk("hs1_y",   64'(y_o),  64'h0000_0F00);
    chk("hs1_co",  64'(co_o), 64'd1);
    @(posedge clk); #1;
    chk("hs_ready_rise", 64'(ready), 64'd1);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    chk("hs2_lat", 64'(lat),  64'd2);
    chk("hs2_y",   64'(y_o),  64'hFFFF_FFFE);
    chk("hs2_co",  64'(co_o), 64'd1);
    repeat (6) @(posedge clk);
    #1;
    chk("hs_done_count", 64'(done_cnt - d0), 64'd2);

    // Reset in the middle of a long shift.
    mode_i  = SH_LSR;
    a_i     = 32'hFFFF_FFFF;
    shamt_i = 8'd31;
    ci_i    = 1'b1;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mrst_ready", 64'(ready), 64'd1);
    chk("mrst_done",  64'(done),  64'd0);
    chk("mrst_y",     64'(y_o),   64'd0);
    chk("mrst_co",    64'(co_o),  64'd0);
    d0 = done_cnt;
    repeat (8) @(posedge clk);
    #1;
    chk("mrst_no_done", 64'(done_cnt - d0), 64'd0);
    chk("mrst_y_hold",  64'(y_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/iterative_barrel_shifter.md
Name: iterative_barrel_shifter

Overview:
- Multi-cycle, parametrised shift unit for the datapath's register-specified shifts: LSL, LSR, ASR and ROR on a WIDTH-bit operand.
- Shifts by up to STEP bit positions per cycle until the effective amount is consumed.
- Produces the ARM shifter carry-out: the last bit shifted out, or carry_in when no shift occurs.
- Sits beside the ALU; the control unit starts it and waits for done.

Parameters:
- WIDTH, 32, operand/result width; power of 2, >= 4.
- SHAMT_W, 8, shift-amount width; matches Rs[7:0]. Must satisfy 2**SHAMT_W > WIDTH.
- STEP, 8, maximum positions shifted per cycle; power of 2, 1..WIDTH.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request; accepted only when ready=1.
- mode  in  2  shift type, sampled at accept: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- A  in  WIDTH  operand, sampled at accept.
- shamt  in  SHAMT_W  unsigned shift amount, sampled at accept.
- carry_in  in  1  current C flag, sampled at accept.
- ready  out  1  high when idle and able to accept start.
- done  out  1  one-cycle pulse when Y/carry_out are valid.
- Y  out  WIDTH  result; held stable from done until the next accept.
- carry_out  out  1  shifter carry; held with Y.

Behaviour:
- Reset (rst_n=0 at a clock edge): state IDLE, ready=1, done=0, Y=0, carry_out=0. Reset mid-operation aborts the operation silently; no done is issued.
- States:
  - IDLE: ready=1. start=1 captures A, mode, shamt, carry_in, computes eff, and moves to SHIFT, or to FINISH if eff=0.
  - SHIFT: ready=0. Each cycle shifts the working register by s=min(rem, STEP), updates the carry, and sets rem -= s. When rem reaches 0, moves to FINISH.
  - FINISH: ready=0. done=1 for this cycle; Y and carry_out are driven from the working register. Next state is IDLE.
- start while ready=0 is ignored; it is not queued.
- Effective amount, with n=shamt:
  - n=0, any mode: eff=0; Y=A, carry_out=carry_in.
  - LSL/LSR: eff=min(n, WIDTH+1).
  - ASR: eff=min(n, WIDTH).
  - ROR with n!=0: eff=n mod WIDTH, or WIDTH when n mod WIDTH = 0.
- Per-step rules:
  - LSL fills zeros; carry = last bit out of the MSB.
  - LSR fills zeros; carry = last bit out of the LSB.
  - ASR fills the sign bit; carry = last bit out of the LSB.
  - ROR rotates; carry = the new MSB.
  - The working register is WIDTH+1 bits ({carry, data}), so the clamped amounts yield the ARM boundary results without special cases:
    - LSL#WIDTH: Y=0, C=A[0].
    - LSL>WIDTH: Y=0, C=0.
    - LSR#WIDTH: Y=0, C=A[WIDTH-1].
    - ASR>=WIDTH: Y=all sign bits, C=sign.
    - ROR by a multiple of WIDTH: Y=A, C=A[WIDTH-1].
- Latency: with the start accept edge at cycle 0, done is high during cycle 1+ceil(eff/STEP). ready returns high the cycle after done. Back-to-back: start may be asserted in the cycle ready rises.
- Y and carry_out change only on the transition into FINISH and on reset.

Decomposition:
- Shared package, shifter_pkg:
  - mode localparams SH_LSL=2'b00, SH_LSR=2'b01, SH_ASR=2'b10, SH_ROR=2'b11.
  - state encodings ST_IDLE, ST_SHIFT, ST_FINISH.
- One combinational sub-module, shift_step: inputs {carry, data}, mode, and s (0..STEP); outputs the shifted {carry, data}. It is the generalised, mode-aware successor of the fixed 4-bit shifter, built from mux levels. The top module holds the FSM, the eff computation, the rem counter and the output registers.

Test Plan (WIDTH=32, STEP=8):
- ASR: A=32'h8000_00F0, shamt=4, carry_in=0 -> done at cycle 2; Y=32'hF800_000F, carry_out=0.
- LSR: A=32'h8000_0001, shamt=32 -> eff=32, done at cycle 5; Y=0, carry_out=1. Then shamt=33 -> Y=0, carry_out=0.
- LSL: A=32'h0000_0001, shamt=200 -> eff=33, done at cycle 6; Y=0, carry_out=0. Then shamt=0, carry_in=1 -> done at cycle 1; Y=A, carry_out=1.
- ROR: A=32'h8000_0001, shamt=64 -> Y=32'h8000_0001, carry_out=1. Then shamt=1 -> Y=32'hC000_0000, carry_out=1.
- Handshake: start held high during SHIFT with different A -> ignored, and first result correct. A second start in the same cycle ready rises -> accepted; done pulses exactly once per operation.
- Reset: rst_n low in the middle of SHIFT with shamt=31 -> next cycle ready=1, done=0, Y=0, carry_out=0, and no done appears afterwards.
